// File: rtl/seg_mon_pkg.sv
// Shared 7-segment pattern constants and the pattern-to-code decoder for the marquee monitor.
// Patterns are active-low gfedcba; the marquee drivers' message tables use the same constants.
package seg_mon_pkg;

    localparam logic [6:0] SEG_BLANK    = 7'h7F;
    localparam logic [4:0] CODE_UNKNOWN = 5'd31;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [41:0] FRAME_BLANK = {6{SEG_BLANK}};

    typedef enum logic [1:0] {
        ClsNone,
        ClsRestart,
        ClsShift,
        ClsError
    } frame_class_e;

    function automatic logic [4:0] seg7_to_code(input logic [6:0] pattern);
        logic [4:0] code;
        code = CODE_UNKNOWN;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_HEX[i]) begin
                code = 5'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/segment_scroll_monitor_if.sv
// Segment inputs and decoded event outputs of the scroll monitor.
// The marquee/test side uses master; the monitor uses slave.
interface segment_scroll_monitor_if #(
    parameter int unsigned LEN_W = 6
);
    logic [6:0]       SEG1;
    logic [6:0]       SEG2;
    logic [6:0]       SEG3;
    logic [6:0]       SEG4;
    logic [6:0]       SEG5;
    logic [6:0]       SEG6;
    logic             char_valid;
    logic [4:0]       char_code;
    logic             msg_start;
    logic [LEN_W-1:0] msg_len;
    logic             shift_err;
    logic [15:0]      frame_cnt;

    modport master (
        output SEG1, SEG2, SEG3, SEG4, SEG5, SEG6,
        input  char_valid, char_code, msg_start, msg_len, shift_err, frame_cnt
    );

    modport slave (
        input  SEG1, SEG2, SEG3, SEG4, SEG5, SEG6,
        output char_valid, char_code, msg_start, msg_len, shift_err, frame_cnt
    );
endinterface

// File: rtl/seg_frame_filter.sv
// Synchronizes the 42 segment bits, debounces the frame and strobes once per newly accepted frame,
// presenting the accepted frame together with the one it replaced.
module seg_frame_filter
    import seg_mon_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [41:0] i_frame,
    output logic        o_accept,
    output logic [41:0] o_new,
    output logic [41:0] o_old
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [41:0]      r_sync1;
    logic [41:0]      r_sync2;
    logic [41:0]      r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [41:0]      r_acc;
    logic [41:0]      r_old;
    logic             r_accept;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= FRAME_BLANK;
            r_sync2  <= FRAME_BLANK;
            r_cand   <= FRAME_BLANK;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_acc    <= FRAME_BLANK;
            r_old    <= FRAME_BLANK;
            r_accept <= 1'b0;
        end else begin
            r_sync1  <= i_frame;
            r_sync2  <= r_sync1;
            r_accept <= 1'b0;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else if (!r_done) begin
                if (r_cnt == CNT_LAST) begin
                    // r_done latches so a frame held indefinitely is accepted only once
                    r_done <= 1'b1;
                    if (r_cand != r_acc) begin
                        r_old    <= r_acc;
                        r_acc    <= r_cand;
                        r_accept <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_accept = r_accept;
    assign o_new    = r_acc;
    assign o_old    = r_old;

endmodule

// File: rtl/segment_scroll_monitor.sv
// Receive side of the six-digit marquee: classifies each accepted frame as scroll, restart or
// error, decodes the character entering at SEG1 and keeps message-length and frame counters.
module segment_scroll_monitor
    import seg_mon_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned LEN_W         = 6
) (
    input  logic                    CLK_50MHz,
    input  logic                    Res,
    segment_scroll_monitor_if.slave bus
);

    logic [41:0]  w_frame;
    logic         w_accept;
    logic [41:0]  w_new;
    logic [41:0]  w_old;
    frame_class_e w_cls;

    logic             r_char_valid;
    logic [4:0]       r_char_code;
    logic             r_msg_start;
    logic [LEN_W-1:0] r_msg_len;
    logic             r_shift_err;
    logic [15:0]      r_frame_cnt;

    assign w_frame = {bus.SEG6, bus.SEG5, bus.SEG4, bus.SEG3, bus.SEG2, bus.SEG1};

    seg_frame_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_clk   (CLK_50MHz),
        .i_rst   (Res),
        .i_frame (w_frame),
        .o_accept(w_accept),
        .o_new   (w_new),
        .o_old   (w_old)
    );

    always_comb begin
        w_cls = ClsNone;
        if (w_accept) begin
            if (w_new[41:7] == {5{SEG_BLANK}} && w_new[6:0] != SEG_BLANK) begin
                w_cls = ClsRestart;
            end else if (w_new[41:7] == w_old[34:0]) begin
                w_cls = ClsShift;
            end else begin
                w_cls = ClsError;
            end
        end
    end

    always_ff @(posedge CLK_50MHz) begin
        if (Res) begin
            r_char_valid <= 1'b0;
            r_char_code  <= '0;
            r_msg_start  <= 1'b0;
            r_msg_len    <= '0;
            r_shift_err  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_char_valid <= 1'b0;
            r_msg_start  <= 1'b0;
            r_shift_err  <= 1'b0;
            if (w_accept && r_frame_cnt != 16'hFFFF) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            case (w_cls)
                ClsRestart: begin
                    r_msg_start  <= 1'b1;
                    r_char_valid <= 1'b1;
                    r_char_code  <= seg7_to_code(w_new[6:0]);
                    r_msg_len    <= LEN_W'(1);
                end
                ClsShift: begin
                    // a blank entering at SEG1 is the message tail scrolling out: no character
                    if (w_new[6:0] != SEG_BLANK) begin
                        r_char_valid <= 1'b1;
                        r_char_code  <= seg7_to_code(w_new[6:0]);
                        if (r_msg_len != '1) begin
                            r_msg_len <= r_msg_len + LEN_W'(1);
                        end
                    end
                end
                ClsError: r_shift_err <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.char_valid = r_char_valid;
    assign bus.char_code  = r_char_code;
    assign bus.msg_start  = r_msg_start;
    assign bus.msg_len    = r_msg_len;
    assign bus.shift_err  = r_shift_err;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
